fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline latch. Feeds the control unit's instr input.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/fetch_stage_pipe_latch_ifid.sv | 23 ++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states, IF/ID record and helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, npc: 32'h0, valid: 1'b0};

    // Branch/jump targets are word addresses; the two low bits are discarded.
    function automatic word_t word_align(input word_t addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_pipe_latch_ifid.sv
// IF/ID pipeline register: clear inserts a bubble, enable captures a new record, else hold.
module pipe_latch_ifid
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  enable,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            q <= IFID_BUBBLE;
        end else if (clear) begin
            q <= IFID_BUBBLE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the icache request and the FETCH/DRAIN/HALTED FSM,
// and feeds the IF/ID latch with fetched words or bubbles.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect_en,
    input  word_t redirect_pc,
    input  logic  halt_dec,
    output word_t instr_out,
    output word_t pc_out,
    output word_t npc_out,
    output logic  valid_out
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    word_t        tgt, tgt_next;
    word_t        pc_plus4;
    logic         advance;
    logic         bubble;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            tgt   <= 32'h0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            tgt   <= tgt_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        tgt_next   = tgt;
        advance    = 1'b0;
        bubble     = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect_en) begin
                    bubble = 1'b1;
                    if (ihit) begin
                        pc_next = word_align(redirect_pc);
                    end else begin
                        tgt_next   = word_align(redirect_pc);
                        state_next = DRAIN;
                    end
                end else if (flush) begin
                    bubble = 1'b1;
                    if (ihit) begin
                        pc_next = pc_plus4;
                    end
                end else if (stall) begin
                    bubble = 1'b0;
                end else if (halt_dec && valid_out) begin
                    bubble     = 1'b1;
                    state_next = HALTED;
                end else if (ihit) begin
                    advance = 1'b1;
                    pc_next = pc_plus4;
                end else begin
                    bubble = 1'b1;
                end
            end
            // The miss in flight keeps its address; the newest redirect target wins on completion.
            DRAIN: begin
                bubble = redirect_en || flush || !stall;
                if (redirect_en) begin
                    tgt_next = word_align(redirect_pc);
                end
                if (ihit) begin
                    pc_next    = tgt_next;
                    state_next = FETCH;
                end
            end
            HALTED: begin
                bubble = 1'b1;
                if (redirect_en) begin
                    pc_next    = word_align(redirect_pc);
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign ifid_d = '{instr: iload, pc: pc, npc: pc_plus4, valid: 1'b1};

    pipe_latch_ifid u_ifid (
        .CLK    (CLK),
        .nRST   (nRST),
        .enable (advance),
        .clear  (bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign imemREN   = (state != HALTED);
    assign imemaddr  = pc;
    assign instr_out = ifid_q.instr;
    assign pc_out    = ifid_q.pc;
    assign npc_out   = ifid_q.npc;
    assign valid_out = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_dec;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        valid_out;

    int vectors    = 0;
    int miscompares = 0;

    fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_dec    (halt_dec),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: where the fetcher points, what IF/ID holds, and whether it is
    // running normally, waiting out an abandoned miss, or parked after HALT.
    bit          m_live = 0;
    bit          m_waiting;
    bit          m_parked;
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_inpc;
    bit          m_valid;

    task automatic m_bubble();
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_inpc  = 32'h0;
        m_valid = 0;
    endtask

    always @(posedge CLK) begin
        if (!nRST) begin
            m_live    = 1;
            m_waiting = 0;
            m_parked  = 0;
            m_pc      = 32'h0;
            m_target  = 32'h0;
            m_bubble();
        end else if (m_live) begin
            if (m_parked) begin
                m_bubble();
                if (redirect_en) begin
                    m_pc     = {redirect_pc[31:2], 2'b00};
                    m_parked = 0;
                end
            end else if (m_waiting) begin
                if (redirect_en) m_target = {redirect_pc[31:2], 2'b00};
                if (redirect_en || flush || !stall) m_bubble();
                if (ihit) begin
                    m_pc      = m_target;
                    m_waiting = 0;
                end
            end else if (redirect_en) begin
                m_bubble();
                if (ihit) m_pc = {redirect_pc[31:2], 2'b00};
                else begin
                    m_target  = {redirect_pc[31:2], 2'b00};
                    m_waiting = 1;
                end
            end else if (flush) begin
                m_bubble();
                if (ihit) m_pc = m_pc + 4;
            end else if (stall) begin
                m_valid = m_valid;
            end else if (halt_dec && m_valid) begin
                m_bubble();
                m_parked = 1;
            end else if (ihit) begin
                m_instr = iload;
                m_ipc   = m_pc;
                m_inpc  = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end else begin
                m_bubble();
            end
        end
    end

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (m_live) begin
            check_value("model imemaddr", imemaddr, m_pc);
            check_value("model imemREN", {31'h0, imemREN}, {31'h0, !m_parked});
            check_value("model instr_out", instr_out, m_instr);
            check_value("model pc_out", pc_out, m_ipc);
            check_value("model npc_out", npc_out, m_inpc);
            check_value("model valid_out", {31'h0, valid_out}, {31'h0, m_valid});
        end
    end

    task automatic apply_stimulus(input bit rst_n, input bit hit, input logic [31:0] word,
                                  input bit stl, input bit fls, input bit redir,
                                  input logic [31:0] target, input bit halt);
        nRST        = rst_n;
        ihit        = hit;
        iload       = word;
        stall       = stl;
        flush       = fls;
        redirect_en = redir;
        redirect_pc = target;
        halt_dec    = halt;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] addr, input bit ren,
                                input bit vld, input logic [31:0] instr,
                                input logic [31:0] ipc, input logic [31:0] inpc);
        check_value({tag, " imemaddr"}, imemaddr, addr);
        check_value({tag, " imemREN"}, {31'h0, imemREN}, {31'h0, ren});
        check_value({tag, " valid_out"}, {31'h0, valid_out}, {31'h0, vld});
        check_value({tag, " instr_out"}, instr_out, instr);
        check_value({tag, " pc_out"}, pc_out, ipc);
        check_value({tag, " npc_out"}, npc_out, inpc);
    endtask

    initial begin
        logic [31:0] rp;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("reset", 32'h0, 1, 0, 32'h0, 32'h0, 32'h0);

        // Straight-line fetch, then a three-cycle miss at 8.
        apply_stimulus(1, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        check_output("fetch A", 32'h4, 1, 1, 32'hAAAA_0001, 32'h0, 32'h4);
        apply_stimulus(1, 1, 32'hBBBB_0002, 0, 0, 0, 0, 0);
        check_output("fetch B", 32'h8, 1, 1, 32'hBBBB_0002, 32'h4, 32'h8);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
            check_output("miss", 32'h8, 1, 0, 32'h0, 32'h0, 32'h0);
        end
        apply_stimulus(1, 1, 32'hCCCC_0003, 0, 0, 0, 0, 0);
        check_output("fetch C", 32'hC, 1, 1, 32'hCCCC_0003, 32'h8, 32'hC);

        // Stall holds everything; the ignored hit is re-fetched afterwards.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 1, 32'h1111_1111, 1, 0, 0, 0, 0);
            check_output("stall", 32'hC, 1, 1, 32'hCCCC_0003, 32'h8, 32'hC);
        end
        apply_stimulus(1, 1, 32'hDDDD_0004, 0, 0, 0, 0, 0);
        check_output("refetch D", 32'h10, 1, 1, 32'hDDDD_0004, 32'hC, 32'h10);

        // Redirect during a miss drains the old request before moving to 0x40.
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h40, 0);
        check_output("drain enter", 32'h10, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        check_output("drain wait", 32'h10, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'hEEEE_0005, 0, 0, 0, 0, 0);
        check_output("drain done", 32'h40, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'hFFFF_0006, 0, 0, 0, 0, 0);
        check_output("fetch F", 32'h44, 1, 1, 32'hFFFF_0006, 32'h40, 32'h44);

        // HALT parks the fetcher until a redirect.
        apply_stimulus(1, 1, 32'h2222_2222, 0, 0, 0, 0, 1);
        check_output("halt", 32'h44, 0, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'h3333_3333, 1, 1, 0, 0, 0);
        check_output("halted", 32'h44, 0, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h80, 0);
        check_output("unhalt", 32'h80, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'h4444_0007, 0, 0, 0, 0, 0);
        check_output("fetch G", 32'h84, 1, 1, 32'h4444_0007, 32'h80, 32'h84);

        // Flush beats stall; reset in DRAIN returns to PC_INIT.
        apply_stimulus(1, 1, 32'h5555_5555, 1, 1, 0, 0, 0);
        check_output("flush+stall", 32'h88, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 0, 1, 32'h20, 0);
        check_output("drain again", 32'h88, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(0, 1, 32'h6666_6666, 0, 0, 0, 0, 0);
        check_output("reset in drain", 32'h0, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'h7777_0008, 0, 0, 0, 0, 0);
        check_output("fetch H", 32'h4, 1, 1, 32'h7777_0008, 32'h0, 32'h4);

        // Unaligned redirect target and PC wrap at the top of memory.
        apply_stimulus(1, 1, 32'h8888_8888, 0, 0, 1, 32'hFFFF_FFFF, 0);
        check_output("redirect top", 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 32'h9999_0009, 0, 0, 0, 0, 0);
        check_output("wrap", 32'h0, 1, 1, 32'h9999_0009, 32'hFFFF_FFFC, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rp = $urandom;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            apply_stimulus($urandom_range(0, 99) != 0,
                           $urandom_range(0, 9) < 7,
                           $urandom,
                           $urandom_range(0, 99) < 15,
                           $urandom_range(0, 99) < 10,
                           $urandom_range(0, 99) < 6,
                           rp,
                           $urandom_range(0, 99) < 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
